seq_sub64b: RTL and testbench



---
 rtl/seq_sub64b_if.sv | 28 ++
 rtl/seq_sub64b.sv | 136 +++++++++++++
 tb/tb_seq_sub64b.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_sub64b_if.sv
// rtl/seq_sub64b_if.sv - operand/result handshake bundle for the digit-serial subtractor
interface seq_sub64b_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             zero;

  // Upstream/downstream side: supplies operands and consumes results
  modport master (
    output in_valid, A, B, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, ovf, zero
  );

  // Subtractor side
  modport slave (
    input  in_valid, A, B, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, ovf, zero
  );
endinterface

// File: rtl/seq_sub64b.sv
// rtl/seq_sub64b.sv - multi-cycle subtractor, one DIGIT-bit slice per clock with a registered borrow
module seq_sub64b #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_sub64b_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             in_ready;
  logic             out_valid;

  // Operands shift right one digit per RUN cycle, so the active digit is always at bit 0
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  // Operand sign bits are shifted out during RUN, so keep them for the overflow flag
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    k;
  // Partial result fills from the top; after N shifts digit 0 sits at bit 0
  logic [WIDTH-1:0] res_reg;

  logic [DIGIT:0]   digit_sub;
  logic [WIDTH-1:0] res_next;
  logic             last_digit;

  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  assign digit_sub  = {1'b0, a_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]}
                    - (DIGIT+1)'(borrow_reg);
  assign res_next   = {digit_sub[DIGIT-1:0], res_reg[WIDTH-1:DIGIT]};
  assign last_digit = (k == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers: load on accept, then consume one digit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      k          <= '0;
      res_reg    <= '0;
    end else if (accept) begin
      a_reg      <= bus.A;
      b_reg      <= bus.B;
      borrow_reg <= bus.borrow_in;
      a_msb      <= bus.A[WIDTH-1];
      b_msb      <= bus.B[WIDTH-1];
      k          <= '0;
      res_reg    <= '0;
    end else if (state == RUN) begin
      a_reg      <= a_reg >> DIGIT;
      b_reg      <= b_reg >> DIGIT;
      borrow_reg <= digit_sub[DIGIT];
      res_reg    <= res_next;
      k          <= k + CW'(1);
    end
  end

  // Result registers: captured only when the final digit completes, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      zero_reg       <= 1'b0;
    end else if (state == RUN && last_digit) begin
      diff_reg       <= res_next;
      borrow_out_reg <= digit_sub[DIGIT];
      ovf_reg        <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      zero_reg       <= ~|res_next;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_out_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.zero       = zero_reg;
endmodule

// File: tb/tb_seq_sub64b.sv
// tb/tb_seq_sub64b.sv - self-checking bench for seq_sub64b against an arithmetic reference
module tb_seq_sub64b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] obs_diff;
  logic        obs_borrow;
  logic        obs_ovf;
  logic        obs_zero;

  seq_sub64b_if #(.WIDTH(64)) bus ();

  seq_sub64b #(.WIDTH(64), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference: plain 65-bit unsigned arithmetic and the flag rules
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                       output logic [63:0] d, output logic bo, output logic ov, output logic z);
    logic [64:0] wide;
    wide = {1'b0, a} - {1'b0, b} - 65'(bin);
    d    = wide[63:0];
    bo   = ({1'b0, b} + 65'(bin)) > {1'b0, a};
    ov   = (a[63] != b[63]) && (d[63] != a[63]);
    z    = (d == 64'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin, input int hold);
    int          cnt;
    logic [63:0] ed;
    logic        eb, eo, ez;
    cnt = 0;
    while (bus.in_ready !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.borrow_in = bin;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.A         = rand64();
    bus.B         = rand64();
    bus.borrow_in = 1'($urandom_range(0, 1));
    chk("in_ready_run", 64'(bus.in_ready), 64'd0);
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'd16);
    model(a, b, bin, ed, eb, eo, ez);
    obs_diff   = bus.diff;
    obs_borrow = bus.borrow_out;
    obs_ovf    = bus.ovf;
    obs_zero   = bus.zero;
    chk("diff", obs_diff, ed);
    chk("borrow_out", 64'(obs_borrow), 64'(eb));
    chk("ovf", 64'(obs_ovf), 64'(eo));
    chk("zero", 64'(obs_zero), 64'(ez));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.A         = rand64();
      bus.B         = rand64();
      bus.borrow_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_diff", bus.diff, ed);
      chk("hold_flags", {61'd0, bus.borrow_out, bus.ovf, bus.zero}, {61'd0, eb, eo, ez});
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("in_ready_after", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int viol;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b0;

    // Reset asserted from time zero
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_diff", bus.diff, 64'd0);
    chk("rst_flags", {61'd0, bus.borrow_out, bus.ovf, bus.zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(64'd5, 64'd3, 1'b0, 0);
    chk("d_5m3", obs_diff, 64'd2);
    run_op(64'd0, 64'd1, 1'b0, 0);
    chk("d_0m1", obs_diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_0m1", 64'(obs_borrow), 64'd1);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
    chk("d_minm1", obs_diff, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("ovf_minm1", 64'(obs_ovf), 64'd1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
    chk("zero_eq", 64'(obs_zero), 64'd1);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
    chk("d_eq_bin", obs_diff, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zero_eq_bin", 64'(obs_zero), 64'd0);

    // Backpressure in DONE, then a following operation
    run_op(rand64(), rand64(), 1'b1, 5);
    run_op(64'd100, 64'd58, 1'b0, 0);

    // Randomized operations, some with backpressure
    for (int i = 0; i < 20; i++) begin
      run_op(rand64(), rand64(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of RUN aborts the operation
    bus.in_valid = 1'b1;
    bus.A        = 64'hDEAD_BEEF_0000_1234;
    bus.B        = 64'h0000_0000_0000_0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst_diff", bus.diff, 64'd0);
    chk("mrst_flags", {61'd0, bus.borrow_out, bus.ovf, bus.zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) viol++;
    end
    chk("mrst_no_valid", 64'(viol), 64'd0);
    run_op(64'h10, 64'h01, 1'b0, 0);
    chk("post_rst_diff", obs_diff, 64'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
